tohost_console: RTL and testbench
=================================

# tohost_console

Console output stage between the core's data-memory write port and the UART transmitter. Snoops core stores, decodes the tohost word (char in [7:0], cmd in [17:16]), and buffers print characters in a ring queue. Drains the queue into the byte-wide UART transmitter with a one-byte-per-ready handshake. Also latches the program's exit command for the board-level halt/LED logic.

## Interface
- QUEUE_SIZE, 64, queue depth in bytes; power of two, ≥4
- CLK  in  1  system clock
- RST  in  1  reset; synchronous and active-high
- D_ADDR  in  32  core data address
- D_WE  in  4  core byte write enables
- WD_DATA  in  32  core store data
- TX_READY  in  1  UART transmitter idle
- TX_DATA  out  8  byte to transmit; 0 when TX_WE=0
- TX_WE  out  1  one-cycle transmit strobe
- HALT  out  1  sticky; exit command received
- EXIT_CODE  out  16  WD_DATA[15:0] of the exit command
- OVERFLOW  out  1  sticky; a print char was dropped
- COUNT  out  $clog2(QUEUE_SIZE)+1  bytes currently queued
- DRAINED  out  1  HALT & COUNT==0 & TX_READY & !TX_WE

## Operation
- Stage A (registered): hit = D_ADDR[30] & D_ADDR[15] & D_WE[0]; WD_DATA captured.
- Stage B (registered): cmd = hit ? data[17:16] : 0; char = hit ? data[7:0] : 0.
- cmd 1, print: enqueue char at (head+COUNT) mod QUEUE_SIZE; COUNT+1.
- cmd 2, exit: HALT←1, EXIT_CODE←data[15:0]. While HALT=1, all later cmds are ignored.
- cmd 0 and cmd 3: no effect.
- Full (COUNT==QUEUE_SIZE) on print: char dropped, OVERFLOW←1, COUNT unchanged.
- Issue condition: COUNT>0 & TX_READY & !TX_WE.
- On issue: TX_WE←1, TX_DATA←queue[head], head+1, COUNT-1.
- Enqueue and dequeue in the same cycle: COUNT unchanged, both pointers advance. An enqueue into a full queue is not rescued by a simultaneous dequeue; the char is still dropped.
- head wraps modulo QUEUE_SIZE. COUNT has one extra bit so that full and empty are distinct.
- Transmit FSM:
  - TX_IDLE→TX_STROBE on issue.
  - TX_STROBE→TX_IDLE unconditionally.
  - TX_WE=1 only in TX_STROBE.
- Reset values: TX_DATA=0, TX_WE=0, HALT=0, EXIT_CODE=0, OVERFLOW=0, COUNT=0, DRAINED=0. Head pointer, pipeline registers and FSM are also cleared. Queue RAM contents are not reset.
- Reset mid-transfer: queue contents are discarded, TX_WE=0 from the next cycle, and no partial CR/LF state survives.

## Timing
- Store presented in cycle n → stage A valid n+1 → stage B valid n+2 → COUNT updated n+3 → TX_WE earliest in n+4, with empty queue and TX_READY=1.
- Back-to-back print stores every cycle are accepted without loss until full.
- TX_WE is never high in two consecutive cycles. TX_READY is treated as low-by-protocol in the cycle after TX_WE.
- HALT and EXIT_CODE update in cycle n+3.
- DRAINED is combinational from registered state.

## Configuration
- CONSOLE_CRLF_EN defined:
  - When head byte is 0x0A and the cr_sent flag is clear, issue 0x0D without popping and set cr_sent.
  - The next issue sends 0x0A, pops it, and clears cr_sent.
  - cr_sent clears on reset.
  - DRAINED additionally requires cr_sent=0.
- CONSOLE_CRLF_EN undefined: bytes are sent verbatim; no cr_sent register exists.

## Test plan
- Reset, then store 0x0001_0041 to 0x4000_8000 with D_WE=0001, TX_READY=1 → TX_WE in cycle n+4 with TX_DATA=0x41; COUNT 0→1→0.
- 70 consecutive print stores with TX_READY=0 and QUEUE_SIZE=64 → COUNT=64, OVERFLOW=1. Then TX_READY=1 → exactly the first 64 bytes are sent in order, across head wrap.
- Store 0x0002_0007, then a print store → HALT=1, EXIT_CODE=7, print ignored, DRAINED=1 once idle.
- Stores with D_ADDR[15]=0, or D_WE=1110, or cmd 0/3 → COUNT stays 0, no TX_WE.
- CONSOLE_CRLF_EN: print 0x0A → TX_DATA sequence 0x0D, 0x0A on two separate strobes. Without the macro, 0x0A only.
- RST asserted with 10 bytes queued mid-drain → next cycle COUNT=0, TX_WE=0, all sticky flags 0; a new print afterwards emits only the new byte.

Source files
------------

// File: rtl/tohost_console.sv
// Console output stage: snoops tohost stores, queues print chars, drains them to a UART.
// Optional CR-before-LF expansion is enabled by defining CONSOLE_CRLF_EN.
module tohost_console #(
  parameter int QUEUE_SIZE = 64
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [31:0]                   D_ADDR,
  input  logic [3:0]                    D_WE,
  input  logic [31:0]                   WD_DATA,
  input  logic                          TX_READY,
  output logic [7:0]                    TX_DATA,
  output logic                          TX_WE,
  output logic                          HALT,
  output logic [15:0]                   EXIT_CODE,
  output logic                          OVERFLOW,
  output logic [$clog2(QUEUE_SIZE):0]   COUNT,
  output logic                          DRAINED
);
  localparam int PW = $clog2(QUEUE_SIZE);
  localparam int CW = PW + 1;

  typedef enum logic {TX_IDLE, TX_STROBE} tx_state_e;

  logic            a_hit_q;
  logic [17:0]     a_data_q;
  logic [1:0]      b_cmd_q;
  logic [15:0]     b_data_q;

  logic [7:0]      mem [QUEUE_SIZE];
  logic [PW-1:0]   head_q, head_d, tail;
  logic [CW-1:0]   count_q, count_d;
  logic            halt_q, halt_d;
  logic [15:0]     exit_q, exit_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      tx_data_q, tx_data_d;
  tx_state_e       state_q, state_d;

  logic            print, exit_cmd, full, enq, issue, pop;
  logic [7:0]      head_byte, tx_byte;

  // Address/data bits outside the decoded fields are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{D_ADDR[31], D_ADDR[29:16], D_ADDR[14:0], D_WE[3:1], WD_DATA[31:18]};

  assign print     = (b_cmd_q == 2'd1) && !halt_q;
  assign exit_cmd  = (b_cmd_q == 2'd2) && !halt_q;
  assign full      = (count_q == CW'(QUEUE_SIZE));
  // A simultaneous pop does not make room: full is judged on the current count.
  assign enq       = print && !full;
  assign issue     = (count_q != '0) && TX_READY && (state_q == TX_IDLE);
  assign head_byte = mem[head_q];
  assign tail      = head_q + count_q[PW-1:0];

`ifdef CONSOLE_CRLF_EN
  logic cr_sent_q, cr_sent_d, send_cr;
  assign send_cr = issue && (head_byte == 8'h0A) && !cr_sent_q;
  assign pop     = issue && !send_cr;
  assign tx_byte = send_cr ? 8'h0D : head_byte;
  always_comb begin
    cr_sent_d = cr_sent_q;
    if (send_cr)  cr_sent_d = 1'b1;
    else if (pop) cr_sent_d = 1'b0;
  end
  always_ff @(posedge CLK) begin
    if (RST) cr_sent_q <= 1'b0;
    else     cr_sent_q <= cr_sent_d;
  end
  assign DRAINED = halt_q && (count_q == '0) && TX_READY && !TX_WE && !cr_sent_q;
`else
  assign pop     = issue;
  assign tx_byte = head_byte;
  assign DRAINED = halt_q && (count_q == '0) && TX_READY && !TX_WE;
`endif

  always_comb begin
    head_d    = head_q;
    count_d   = count_q + CW'(enq) - CW'(pop);
    halt_d    = halt_q;
    exit_d    = exit_q;
    ovf_d     = ovf_q;
    tx_data_d = 8'h00;
    if (pop) head_d = head_q + PW'(1);
    if (print && full) ovf_d = 1'b1;
    if (exit_cmd) begin
      halt_d = 1'b1;
      exit_d = b_data_q;
    end
    if (issue) tx_data_d = tx_byte;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:   if (issue) state_d = TX_STROBE;
      TX_STROBE: state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_hit_q   <= 1'b0;
      a_data_q  <= '0;
      b_cmd_q   <= 2'd0;
      b_data_q  <= '0;
      head_q    <= '0;
      count_q   <= '0;
      halt_q    <= 1'b0;
      exit_q    <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= '0;
      state_q   <= TX_IDLE;
    end else begin
      a_hit_q   <= D_ADDR[30] & D_ADDR[15] & D_WE[0];
      a_data_q  <= WD_DATA[17:0];
      b_cmd_q   <= a_hit_q ? a_data_q[17:16] : 2'd0;
      b_data_q  <= a_hit_q ? a_data_q[15:0] : 16'd0;
      head_q    <= head_d;
      count_q   <= count_d;
      halt_q    <= halt_d;
      exit_q    <= exit_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
      state_q   <= state_d;
    end
  end

  // Queue storage is not reset; count/head define what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && enq) mem[tail] <= b_data_q[7:0];
  end

  assign TX_WE     = (state_q == TX_STROBE);
  assign TX_DATA   = tx_data_q;
  assign HALT      = halt_q;
  assign EXIT_CODE = exit_q;
  assign OVERFLOW  = ovf_q;
  assign COUNT     = count_q;
endmodule

// File: tb/tb_tohost_console.sv
// Directed bench for tohost_console: vector table plus hand-written multi-cycle sequences.
module tb_tohost_console;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] D_ADDR;
  logic [3:0]  D_WE;
  logic [31:0] WD_DATA;
  logic        TX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_WE;
  logic        HALT;
  logic [15:0] EXIT_CODE;
  logic        OVERFLOW;
  logic [6:0]  COUNT;
  logic        DRAINED;

  tohost_console #(.QUEUE_SIZE(64)) dut (
    .CLK(CLK), .RST(RST), .D_ADDR(D_ADDR), .D_WE(D_WE), .WD_DATA(WD_DATA),
    .TX_READY(TX_READY), .TX_DATA(TX_DATA), .TX_WE(TX_WE), .HALT(HALT),
    .EXIT_CODE(EXIT_CODE), .OVERFLOW(OVERFLOW), .COUNT(COUNT), .DRAINED(DRAINED)
  );

  always #5 CLK = ~CLK;

  int ncmp = 0, nfail = 0, viol = 0;
  logic [7:0] log_q[$];
  logic prev_we = 1'b0;

  // Record every strobed byte and watch the strobe protocol.
  always @(negedge CLK) begin
    if (TX_WE) log_q.push_back(TX_DATA);
    if (TX_WE && prev_we) viol++;
    if (!TX_WE && TX_DATA != 8'h00) viol++;
    prev_we = TX_WE;
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
    int          n;
    logic [7:0]  ch;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    D_ADDR = a; D_WE = w; WD_DATA = d;
    cyc(1);
    D_ADDR = '0; D_WE = '0; WD_DATA = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h4000_8000, 4'b0001, 32'h0001_0041, 1, 8'h41};
    tbl[1] = '{32'h4000_0000, 4'b0001, 32'h0001_0042, 0, 8'h00};
    tbl[2] = '{32'h0000_8000, 4'b0001, 32'h0001_0043, 0, 8'h00};
    tbl[3] = '{32'h4000_8000, 4'b1110, 32'h0001_0044, 0, 8'h00};
    tbl[4] = '{32'h4000_8000, 4'b0001, 32'h0000_0045, 0, 8'h00};
    tbl[5] = '{32'h4000_8000, 4'b0001, 32'h0003_0046, 0, 8'h00};
    tbl[6] = '{32'hC000_FFFC, 4'b1111, 32'h0001_005A, 1, 8'h5A};
    tbl[7] = '{32'h4000_8000, 4'b0001, 32'hFFFD_0061, 1, 8'h61};

    D_ADDR = '0; D_WE = '0; WD_DATA = '0; TX_READY = 1'b1;
    do_reset();
    chk("rst_count", COUNT, 0);
    chk("rst_tx_we", TX_WE, 0);
    chk("rst_tx_data", TX_DATA, 0);
    chk("rst_halt", HALT, 0);
    chk("rst_exit", EXIT_CODE, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_drained", DRAINED, 0);

    // Latency: store in n, COUNT at n+3, strobe at n+4.
    store(32'h4000_8000, 4'b0001, 32'h0001_0041);
    chk("lat_cnt_n1", COUNT, 0);
    cyc(1);
    chk("lat_cnt_n2", COUNT, 0);
    cyc(1);
    chk("lat_cnt_n3", COUNT, 1);
    chk("lat_we_n3", TX_WE, 0);
    cyc(1);
    chk("lat_we_n4", TX_WE, 1);
    chk("lat_data_n4", TX_DATA, 8'h41);
    chk("lat_cnt_n4", COUNT, 0);
    cyc(1);
    chk("lat_we_n5", TX_WE, 0);

    for (int i = 0; i < 8; i++) begin
      log_q.delete();
      store(tbl[i].addr, tbl[i].we, tbl[i].data);
      cyc(8);
      chk($sformatf("vec%0d_nbytes", i), log_q.size(), tbl[i].n);
      chk($sformatf("vec%0d_byte", i), (log_q.size() > 0) ? log_q[0] : 8'h00, tbl[i].ch);
      chk($sformatf("vec%0d_count", i), COUNT, 0);
    end

    // Overflow: head is nonzero here, so the drain wraps the ring.
    TX_READY = 1'b0;
    for (int i = 0; i < 70; i++) begin
      D_ADDR = 32'h4000_8000; D_WE = 4'b0001; WD_DATA = 32'h0001_0000 | (32'h20 + i);
      cyc(1);
    end
    D_ADDR = '0; D_WE = '0; WD_DATA = '0;
    cyc(2);
    chk("ovf_count", COUNT, 64);
    chk("ovf_flag", OVERFLOW, 1);
    chk("ovf_no_tx", TX_WE, 0);
    log_q.delete();
    TX_READY = 1'b1;
    cyc(64 * 2 + 6);
    chk("ovf_nbytes", log_q.size(), 64);
    for (int i = 0; i < 64; i++)
      chk($sformatf("ovf_byte%0d", i), (i < log_q.size()) ? log_q[i] : 8'hxx, 8'(32'h20 + i));
    chk("ovf_drained_count", COUNT, 0);
    chk("ovf_sticky", OVERFLOW, 1);

    // Exit command, then a print that must be ignored.
    do_reset();
    log_q.delete();
    store(32'h4000_8000, 4'b0001, 32'h0002_0007);
    store(32'h4000_8000, 4'b0001, 32'h0001_0041);
    chk("exit_halt_n2", HALT, 0);
    cyc(1);
    chk("exit_halt_n3", HALT, 1);
    chk("exit_code", EXIT_CODE, 16'h0007);
    cyc(6);
    chk("exit_nbytes", log_q.size(), 0);
    chk("exit_count", COUNT, 0);
    chk("exit_drained", DRAINED, 1);
    TX_READY = 1'b0;
    #1;
    chk("exit_drained_notrdy", DRAINED, 0);
    TX_READY = 1'b1;
    store(32'h4000_8000, 4'b0001, 32'h0002_0009);
    cyc(4);
    chk("exit_code_held", EXIT_CODE, 16'h0007);

    // Newline handling.
    do_reset();
    log_q.delete();
    store(32'h4000_8000, 4'b0001, 32'h0001_000A);
    cyc(10);
`ifdef CONSOLE_CRLF_EN
    chk("nl_nbytes", log_q.size(), 2);
    chk("nl_first", (log_q.size() > 0) ? log_q[0] : 8'h00, 8'h0D);
`else
    chk("nl_nbytes", log_q.size(), 1);
    chk("nl_first", (log_q.size() > 0) ? log_q[0] : 8'h00, 8'h0A);
`endif
    chk("nl_last", (log_q.size() > 0) ? log_q[log_q.size()-1] : 8'h00, 8'h0A);
    chk("nl_drained", DRAINED, 0);

    // Reset in the middle of a drain.
    do_reset();
    TX_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      D_ADDR = 32'h4000_8000; D_WE = 4'b0001; WD_DATA = 32'h0001_0030 + i;
      cyc(1);
    end
    store(32'h4000_8000, 4'b0001, 32'h0002_0005);
    cyc(2);
    chk("mid_count", COUNT, 10);
    chk("mid_halt", HALT, 1);
    log_q.delete();
    TX_READY = 1'b1;
    begin
      int t = 0;
      while (!(TX_WE && log_q.size() >= 2) && t < 50) begin cyc(1); t++; end
      chk("mid_wait_timeout", (t < 50) ? 1 : 0, 1);
    end
    RST = 1'b1;
    cyc(1);
    chk("mid_rst_count", COUNT, 0);
    chk("mid_rst_we", TX_WE, 0);
    chk("mid_rst_data", TX_DATA, 0);
    chk("mid_rst_halt", HALT, 0);
    chk("mid_rst_exit", EXIT_CODE, 0);
    chk("mid_rst_ovf", OVERFLOW, 0);
    RST = 1'b0;
    log_q.delete();
    store(32'h4000_8000, 4'b0001, 32'h0001_0055);
    cyc(10);
    chk("post_nbytes", log_q.size(), 1);
    chk("post_byte", (log_q.size() > 0) ? log_q[0] : 8'h00, 8'h55);

    chk("protocol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
